// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable 50%-duty clock divider.
`timescale 1ns/1ps
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    // High-time in whole source cycles: N/2 for even N, (N-1)/2 for odd N.
    function automatic int unsigned half_cnt(input int unsigned n);
        return n >> 1;
    endfunction

    function automatic logic is_odd(input int unsigned n);
        return n[0];
    endfunction

endpackage

// File: rtl/clk_div_negsample.sv
// Falling-edge resample of the divider's posedge pulse; kept alone so the
// negedge domain is a single, easily reviewed flop.
`timescale 1ns/1ps
module clk_div_negsample (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/clk_divide_n.sv
// Runtime-programmable integer clock divider, 50% duty for even and odd N,
// with boundary-only ratio changes, clean stop/start and a phase-0 tick.
`timescale 1ns/1ps
module clk_divide_n
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DIV_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic             clk_out,
    output logic             tick
);

    typedef logic [DIV_W-1:0] div_t;

    localparam div_t DIV_RST   = div_t'(DIV_DEFAULT);
    localparam div_t DIV_FLOOR = div_t'(DIV_MIN);

    div_t phase_q;
    div_t div_act_q;
    div_t div_pend_q;
    logic run_q;
    logic pend_vld_q;
    logic odd_q;
    logic pos_q;
    logic neg_q;
    logic tick_q;

    div_t last_phase;
    div_t phase_next;
    div_t div_next;
    div_t half_next;
    div_t div_clamped;
    logic boundary;
    logic apply_pend;
    logic run_next;

    always_comb begin
        last_phase  = div_act_q - div_t'(1);
        boundary    = en && (!run_q || (phase_q == last_phase));
        apply_pend  = boundary && pend_vld_q;
        div_next    = apply_pend ? div_pend_q : div_act_q;
        run_next    = run_q;
        phase_next  = phase_q;
        if (boundary) begin
            run_next   = 1'b1;
            phase_next = '0;
        end else if (run_q) begin
            // Without en, the last phase of the period parks the counter at 0.
            if (phase_q == last_phase) begin
                run_next   = 1'b0;
                phase_next = '0;
            end else begin
                phase_next = phase_q + div_t'(1);
            end
        end
        half_next   = div_t'(half_cnt(32'(div_next)));
        div_clamped = (div_val < DIV_FLOOR) ? DIV_FLOOR : div_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            run_q      <= 1'b0;
            div_act_q  <= DIV_RST;
            div_pend_q <= DIV_RST;
            pend_vld_q <= 1'b0;
            odd_q      <= is_odd(DIV_DEFAULT);
            pos_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            phase_q   <= phase_next;
            run_q     <= run_next;
            div_act_q <= div_next;
            // Mode flag only moves at a boundary, where pos_q and neg_q are both low.
            odd_q     <= is_odd(32'(div_next));
            pos_q     <= run_next && (phase_next < half_next);
            tick_q    <= run_next && (phase_next == '0);
            if (div_load) begin
                div_pend_q <= div_clamped;
                pend_vld_q <= 1'b1;
            end else if (apply_pend) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    clk_div_negsample u_negsample (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pos_q),
        .q     (neg_q)
    );

    // Odd ratios stretch the high time by half a source cycle via the negedge copy.
    assign clk_out  = pos_q | (odd_q & neg_q);
    assign div_busy = pend_vld_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_clk_divide_n.sv
// Self-checking bench for clk_divide_n: half-cycle waveform model plus
// edge-time measurements of period and high time.
`timescale 1ns/1ps
module tb_clk_divide_n;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_busy;
    logic       clk_out;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    // Reference model: divisor in force, cycle index within the current period.
    bit m_run;
    int m_cyc;
    int m_n;
    int m_pend;
    bit m_pv;

    realtime t_rise_prev = 0.0;
    realtime t_rise      = 0.0;
    realtime t_fall      = 0.0;

    clk_divide_n #(.DIV_W(8), .DIV_DEFAULT(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_busy (div_busy),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk_out) begin
        t_rise_prev = t_rise;
        t_rise      = $realtime;
    end

    always @(negedge clk_out) t_fall = $realtime;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run  = 1'b0;
        m_cyc  = 0;
        m_n    = 5;
        m_pend = 5;
        m_pv   = 1'b0;
    endfunction

    // One source-clock edge of the spec's phase rules.
    function automatic void model_edge(input logic e, input logic ld, input logic [7:0] v);
        bit applied;
        applied = 1'b0;
        if (e && (!m_run || m_cyc == m_n - 1)) begin
            if (m_pv) begin
                m_n     = m_pend;
                applied = 1'b1;
            end
            m_run = 1'b1;
            m_cyc = 0;
        end else if (m_run) begin
            if (m_cyc == m_n - 1) begin
                m_run = 1'b0;
                m_cyc = 0;
            end else begin
                m_cyc++;
            end
        end
        if (ld) begin
            m_pend = (int'(v) < 2) ? 2 : int'(v);
            m_pv   = 1'b1;
        end else if (applied) begin
            m_pv = 1'b0;
        end
    endfunction

    // 50% duty: clk_out is high for the first N of the 2N half-cycles of a period.
    function automatic logic exp_clk(input int half);
        return m_run && (half < m_n);
    endfunction

    // Called at negedge+2; returns at the following negedge+2.
    task automatic step(input logic e, input logic ld, input logic [7:0] v);
        en       = e;
        div_load = ld;
        div_val  = v;
        @(posedge clk);
        model_edge(e, ld, v);
        #2;
        chk("clk_out_first_half", clk_out, exp_clk(2 * m_cyc));
        chk("tick", tick, m_run && (m_cyc == 0));
        chk("div_busy", div_busy, m_pv);
        @(negedge clk);
        #2;
        chk("clk_out_second_half", clk_out, exp_clk(2 * m_cyc + 1));
        div_load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'd0);
    endtask

    task automatic run_until_applied();
        int k;
        k = 0;
        while (m_pv && k < 600) begin
            step(1'b1, 1'b0, 8'd0);
            k++;
        end
        chk("pending_applied_in_budget", m_pv, 1'b0);
    endtask

    task automatic run_until_phase0();
        int k;
        k = 0;
        do begin
            step(1'b1, 1'b0, 8'd0);
            k++;
        end while (!(m_run && m_cyc == 0) && k < 600);
        chk("phase0_in_budget", m_run && (m_cyc == 0), 1'b1);
    endtask

    // Measures the last complete period and the high time of the current one.
    task automatic check_timing(input string tag, input int n);
        int k;
        k = 0;
        while (!(m_run && 2 * m_cyc >= m_n) && k < 600) begin
            step(1'b1, 1'b0, 8'd0);
            k++;
        end
        chk_int({tag, "_period_ns"}, int'(t_rise - t_rise_prev), n * 10);
        chk_int({tag, "_high_ns"}, int'(t_fall - t_rise), n * 5);
    endtask

    initial begin
        logic en_r;
        rst_n    = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = 8'd0;
        model_reset();
        #1 rst_n = 1'b0;
        #50;
        chk("reset_clk_out", clk_out, 1'b0);
        chk("reset_tick", tick, 1'b0);
        chk("reset_div_busy", div_busy, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Default N=5: first rise at first posedge with en=1.
        run(20);
        check_timing("n5_default", 5);

        // Load 4 mid-period; busy until the boundary, current period unaffected.
        while (m_cyc != 2) step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'd4);
        run_until_applied();
        run(12);
        check_timing("n4", 4);

        // Load 7 then 3 before the boundary: only 3 takes effect.
        run_until_phase0();
        step(1'b1, 1'b1, 8'd7);
        step(1'b1, 1'b1, 8'd3);
        run_until_applied();
        run(10);
        check_timing("n3_last_wins", 3);

        // Back to 5, then drop en just after a rise.
        step(1'b1, 1'b1, 8'd5);
        run_until_applied();
        run(12);
        run_until_phase0();
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'd0);
        chk_int("stop_high_ns", int'(t_fall - t_rise), 25);
        chk("stopped_low", clk_out, 1'b0);
        run(12);
        check_timing("n5_restart", 5);

        // Clamp of 0 and 1, then full-scale 255.
        step(1'b1, 1'b1, 8'd0);
        run(3);
        step(1'b1, 1'b1, 8'd1);
        run_until_applied();
        run(8);
        check_timing("n2_clamp", 2);
        step(1'b1, 1'b1, 8'd255);
        run_until_applied();
        run(300);
        check_timing("n255", 255);

        // Asynchronous reset while clk_out is high and a load is pending.
        run_until_phase0();
        step(1'b1, 1'b1, 8'd9);
        chk("pre_reset_high", clk_out, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_clk_out", clk_out, 1'b0);
        chk("async_reset_div_busy", div_busy, 1'b0);
        chk("async_reset_tick", tick, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        run(20);
        check_timing("n5_after_reset", 5);

        // Randomized en toggling and loads.
        en_r = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) en_r = ~en_r;
            step(en_r, ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 9)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
